// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: control-bundle layout, opcode constants and halt FSM encoding.
package riscv_pkg;

    localparam int CTRL_W         = 11;
    localparam int CTRL_REGWRITE  = 10;
    localparam int CTRL_IMMSRC_HI = 9;
    localparam int CTRL_IMMSRC_LO = 8;
    localparam int CTRL_ALUSRC    = 7;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_RESSRC_HI = 5;
    localparam int CTRL_RESSRC_LO = 4;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_ALUOP_HI  = 2;
    localparam int CTRL_ALUOP_LO  = 1;
    localparam int CTRL_JUMP      = 0;

    localparam logic [6:0] OP_ECALL   = 7'b1110011;
    localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer (MAIN drives the output, SKID absorbs one beat of
// backpressure) with a registered upstream ready and a synchronous flush.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         empty_o
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         ready_q;

    // Next-state of both entries; flush wins over any same-cycle accept.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || ready_i) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = push_i;
                skid_d       = push_i ? data_i : skid_q;
            end else if (push_i) begin
                main_d       = data_i;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (push_i) begin
            skid_d       = data_i;
            skid_valid_d = 1'b1;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // Entry storage and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= {W{1'b0}};
            skid_q       <= {W{1'b0}};
            ready_q      <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = main_valid_q;
    assign data_o  = main_q;
    assign empty_o = !main_valid_q && !skid_valid_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register built on a two-entry skid buffer, with bubble masking of the control
// bundle. Define ID_EX_ECALL_HALT_EN to enable the ECALL drain-and-halt sequence.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_is_ecall,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_pc4,
    input  logic [XLEN-1:0]   in_rd1,
    input  logic [XLEN-1:0]   in_rd2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_pc4,
    output logic [XLEN-1:0]   out_rd1,
    output logic [XLEN-1:0]   out_rd2,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [2:0]        out_funct3,
    output logic              out_funct7b5,
    output logic              halted
);
    import riscv_pkg::*;

    localparam int PAY_W = CTRL_W + 5 * XLEN + 19;

    logic [PAY_W-1:0]  pay_in_s, pay_out_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic              accept_s, push_s, flush_eff_s;
    logic              buf_ready_s, buf_valid_s, buf_empty_s;

    assign pay_in_s = {in_ctrl, in_pc, in_pc4, in_rd1, in_rd2, in_imm,
                       in_rs1, in_rs2, in_rd, in_funct3, in_funct7b5};
    assign {ctrl_s, out_pc, out_pc4, out_rd1, out_rd2, out_imm,
            out_rs1, out_rs2, out_rd, out_funct3, out_funct7b5} = pay_out_s;

    assign accept_s  = in_valid && in_ready;
    assign out_valid = buf_valid_s;
    assign out_ctrl  = buf_valid_s ? ctrl_s : {CTRL_W{1'b0}};

    pipe_skid_buf #(.W(PAY_W)) u_buf (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (flush_eff_s),
        .push_i  (push_s),
        .data_i  (pay_in_s),
        .ready_o (buf_ready_s),
        .valid_o (buf_valid_s),
        .ready_i (out_ready),
        .data_o  (pay_out_s),
        .empty_o (buf_empty_s)
    );

`ifdef ID_EX_ECALL_HALT_EN
    halt_state_e state_q;
    logic        run_q;
    logic        halted_q;

    // The ECALL beat itself is consumed here and never reaches the buffer.
    assign push_s      = accept_s && !in_is_ecall;
    assign flush_eff_s = flush && (state_q != ST_HALTED);
    assign in_ready    = buf_ready_s && run_q;
    assign halted      = halted_q;

    // Halt FSM: RUN -> DRAIN on an accepted ECALL, DRAIN -> HALTED once empty, flush cancels DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            run_q    <= 1'b1;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept_s && in_is_ecall && !flush) begin
                        state_q <= ST_DRAIN;
                        run_q   <= 1'b0;
                    end else begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                    halted_q <= 1'b0;
                end
                ST_DRAIN: begin
                    if (flush) begin
                        state_q  <= ST_RUN;
                        run_q    <= 1'b1;
                        halted_q <= 1'b0;
                    end else if (buf_empty_s) begin
                        state_q  <= ST_HALTED;
                        run_q    <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= ST_DRAIN;
                        run_q    <= 1'b0;
                        halted_q <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    state_q  <= ST_HALTED;
                    run_q    <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_RUN;
                    run_q    <= 1'b1;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_ecall_s;

    assign unused_ecall_s = in_is_ecall;
    assign push_s         = accept_s;
    assign flush_eff_s    = flush;
    assign in_ready       = buf_ready_s;
    assign halted         = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table-driven streaming plus hand-written corner sequences,
// with a scoreboard queue of expected beats popped on every output transfer.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int CW   = 11;
    localparam int BW   = CW + 5 * XLEN + 19;
`ifdef ID_EX_ECALL_HALT_EN
    localparam bit ECALL_ON = 1'b1;
`else
    localparam bit ECALL_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_is_ecall, flush, out_valid, out_ready, halted;
    logic [CW-1:0]   in_ctrl, out_ctrl;
    logic [XLEN-1:0] in_pc, in_pc4, in_rd1, in_rd2, in_imm;
    logic [XLEN-1:0] out_pc, out_pc4, out_rd1, out_rd2, out_imm;
    logic [4:0]      in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
    logic [2:0]      in_funct3, out_funct3;
    logic            in_funct7b5, out_funct7b5;

    typedef struct packed {
        logic [CW-1:0]   ctrl;
        logic [XLEN-1:0] pc, pc4, rd1, rd2, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [2:0]      f3;
        logic            f7;
    } beat_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [CW-1:0]   ctrl;
        logic [XLEN-1:0] exp_pc;
        logic [CW-1:0]   exp_ctrl;
    } vec_t;

    beat_t sb[$];
    beat_t cur_beat;
    vec_t  tbl[8];
    int    n_cmp  = 0;
    int    n_fail = 0;
    logic  last_acc;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_is_ecall(in_is_ecall), .in_pc(in_pc), .in_pc4(in_pc4), .in_rd1(in_rd1),
        .in_rd2(in_rd2), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc(out_pc),
        .out_pc4(out_pc4), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_funct7b5(out_funct7b5), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [XLEN-1:0] pc, input logic [CW-1:0] ctrl);
        beat_t b;
        b.ctrl = ctrl;
        b.pc   = pc;
        b.pc4  = pc + 32'd4;
        b.rd1  = pc ^ 32'hDEAD_0000;
        b.rd2  = ~pc;
        b.imm  = {pc[15:0], 16'h8001};
        b.rs1  = pc[6:2];
        b.rs2  = ~pc[6:2];
        b.rd   = pc[6:2] ^ 5'h15;
        b.f3   = pc[4:2];
        b.f7   = pc[2];
        return b;
    endfunction

    function automatic beat_t dut_out();
        beat_t b;
        b = {out_ctrl, out_pc, out_pc4, out_rd1, out_rd2, out_imm,
             out_rs1, out_rs2, out_rd, out_funct3, out_funct7b5};
        return b;
    endfunction

    task automatic drive(input beat_t b, input logic ec);
        cur_beat    = b;
        in_valid    = 1'b1;
        in_is_ecall = ec;
        {in_ctrl, in_pc, in_pc4, in_rd1, in_rd2, in_imm,
         in_rs1, in_rs2, in_rd, in_funct3, in_funct7b5} = b;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        in_is_ecall = 1'b0;
    endtask

    // One clock: bookkeeping at the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        beat_t exp_b;
        beat_t act_b;
        @(negedge clk);
        if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got beat pc 0x%0h, required no beat", out_pc);
            end else begin
                exp_b = sb.pop_front();
                act_b = dut_out();
                n_cmp++;
                if (act_b !== exp_b) begin
                    n_fail++;
                    $display("FAIL sb_beat: got 0x%0h, required 0x%0h", act_b, exp_b);
                end
            end
        end
        last_acc = in_valid && in_ready;
        if (flush) sb.delete();
        else if (last_acc && !(ECALL_ON && in_is_ecall)) sb.push_back(cur_beat);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        idle();
        for (int k = 0; k < 20; k++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        logic [CW-1:0] pat [8];
        pat = '{11'h490, 11'h1C0, 11'h404, 11'h20A, 11'h721, 11'h484, 11'h7FF, 11'h000};
        for (int i = 0; i < 8; i++) begin
            tbl[i].pc       = 32'(i * 4);
            tbl[i].ctrl     = pat[i];
            tbl[i].exp_pc   = 32'(i * 4);
            tbl[i].exp_ctrl = pat[i];
        end

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(mk(32'h0, 11'h0), 1'b0);
        idle();
        #1 rst = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
        chk("rst_out_pc", 64'(out_pc), 64'(0));
        chk("rst_out_rd1", 64'(out_rd1), 64'(0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;

        // Streaming, table driven.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_in_ready", 64'(in_ready), 64'(1));
            drive(mk(tbl[i].pc, tbl[i].ctrl), 1'b0);
            tick();
            chk("stream_out_valid", 64'(out_valid), 64'(1));
            chk("stream_out_pc", 64'(out_pc), 64'(tbl[i].exp_pc));
            chk("stream_out_ctrl", 64'(out_ctrl), 64'(tbl[i].exp_ctrl));
        end
        drain();

        // Backpressure: third beat waits until the skid entry frees.
        out_ready = 1'b0;
        drive(mk(32'h100, 11'h490), 1'b0); tick();
        chk("bp_ready_after1", 64'(in_ready), 64'(1));
        drive(mk(32'h104, 11'h404), 1'b0); tick();
        chk("bp_ready_low", 64'(in_ready), 64'(0));
        drive(mk(32'h108, 11'h1C0), 1'b0); tick(); tick();
        chk("bp_hold_pc", 64'(out_pc), 64'(32'h100));
        chk("bp_hold_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (last_acc) break;
        end
        chk("bp_third_accepted", 64'(last_acc), 64'(1));
        drain();

        // Flush with both entries full, then flush colliding with a real accept.
        out_ready = 1'b0;
        drive(mk(32'h200, 11'h490), 1'b0); tick();
        drive(mk(32'h204, 11'h484), 1'b0); tick();
        drive(mk(32'h40, 11'h7FF), 1'b0); flush = 1'b1; tick(); flush = 1'b0; idle();
        chk("flush_full_valid", 64'(out_valid), 64'(0));
        chk("flush_full_ctrl", 64'(out_ctrl), 64'(0));
        chk("flush_full_ready", 64'(in_ready), 64'(1));
        drive(mk(32'h300, 11'h484), 1'b0); tick();
        drive(mk(32'h40, 11'h7FF), 1'b0); flush = 1'b1; tick(); flush = 1'b0; idle();
        chk("flush_acc_valid", 64'(out_valid), 64'(0));
        chk("flush_acc_ctrl", 64'(out_ctrl), 64'(0));
        chk("flush_data_hold", 64'(out_pc), 64'(32'h300));
        out_ready = 1'b1;
        drive(mk(32'h500, 11'h20A), 1'b0); tick(); idle();
        drain();

`ifdef ID_EX_ECALL_HALT_EN
        // Speculative ECALL cancelled by a flush during DRAIN.
        out_ready = 1'b1;
        drive(mk(32'h600, 11'h000), 1'b1); tick(); idle();
        chk("spec_ready_drain", 64'(in_ready), 64'(0));
        flush = 1'b1; tick(); flush = 1'b0;
        chk("spec_ready_run", 64'(in_ready), 64'(1));
        tick(); tick();
        chk("spec_not_halted", 64'(halted), 64'(0));
        drive(mk(32'h610, 11'h404), 1'b0); tick(); idle();
        drain();

        // Real ECALL: lw drains after delayed out_ready, then halt.
        out_ready = 1'b0;
        drive(mk(32'h10, 11'h490), 1'b0); tick();
        drive(mk(32'h14, 11'h000), 1'b1); tick(); idle();
        chk("halt_drain_ready", 64'(in_ready), 64'(0));
        tick(); tick(); tick();
        chk("halt_wait_pc", 64'(out_pc), 64'(32'h10));
        chk("halt_wait_halted", 64'(halted), 64'(0));
        out_ready = 1'b1;
        tick();
        chk("halt_after_drain", 64'(halted), 64'(0));
        chk("halt_empty_valid", 64'(out_valid), 64'(0));
        tick();
        chk("halt_set", 64'(halted), 64'(1));
        drive(mk(32'h18, 11'h404), 1'b0); flush = 1'b1; tick(); flush = 1'b0; tick(); tick();
        chk("halt_no_accept", 64'(in_ready), 64'(0));
        chk("halt_no_valid", 64'(out_valid), 64'(0));
        chk("halt_sticky", 64'(halted), 64'(1));
        idle();
        chk("halt_sb_empty", 64'(sb.size()), 64'(0));
        rst = 1'b0;
        #1;
        chk("halt_rst_clear", 64'(halted), 64'(0));
        chk("halt_rst_ready", 64'(in_ready), 64'(1));
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
`else
        // ECALL without the halt feature travels through as an ordinary beat.
        out_ready = 1'b1;
        drive(mk(32'h600, 11'h000), 1'b1); tick(); idle();
        chk("ecall_nop_pc", 64'(out_pc), 64'(32'h600));
        chk("ecall_nop_ready", 64'(in_ready), 64'(1));
        tick();
        chk("ecall_nop_halted", 64'(halted), 64'(0));
        drain();
`endif

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        drive(mk(32'h700, 11'h490), 1'b0); tick();
        drive(mk(32'h704, 11'h721), 1'b0); tick(); idle();
        chk("arst_pre_valid", 64'(out_valid), 64'(1));
        chk("arst_pre_ready", 64'(in_ready), 64'(0));
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_ready", 64'(in_ready), 64'(1));
        chk("arst_halted", 64'(halted), 64'(0));
        chk("arst_ctrl", 64'(out_ctrl), 64'(0));
        chk("arst_pc", 64'(out_pc), 64'(0));
        sb.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;

        out_ready = 1'b1;
        drive(mk(32'h800, 11'h1C0), 1'b0); tick(); idle();
        chk("post_rst_pc", 64'(out_pc), 64'(32'h800));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
